// File: rtl/ctrl_pkg.sv
// Shared encodings for the SPARC-subset control unit: states, mux selects,
// datapath opcodes and instruction field values.
package ctrl_pkg;

    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [4:0] {
        ST_RST, ST_F0, ST_F1, ST_F2, ST_DEC,
        ST_ALU, ST_L0, ST_L1, ST_L2, ST_L3,
        ST_S0, ST_S1, ST_S2, ST_CALL, ST_UPD,
        ST_ILL, ST_MERR
    } state_t;

    // Mux selects
    localparam logic [1:0] MAR_ALU  = 2'd0, MAR_PC   = 2'd1;
    localparam logic [1:0] MDR_RAM  = 2'd0, MDR_RFA  = 2'd1;
    localparam logic [1:0] CIN_PC   = 2'd0, CIN_ALU  = 2'd2, CIN_MDR = 2'd3;
    localparam logic [1:0] RC_IR    = 2'd0, RC_R15   = 2'd3;
    localparam logic [1:0] ALU_RFB  = 2'd0, ALU_SIMM = 2'd1;
    localparam logic [1:0] NPC_INC  = 2'd0, NPC_BR   = 2'd2;

    // Datapath opcodes
    localparam logic [5:0] OP_LDW = 6'h08, OP_STW = 6'h04, OP_ADD = 6'h00;

    // Instruction fields
    localparam logic [1:0] FMT_BR = 2'd0, FMT_CALL = 2'd1, FMT_ALU = 2'd2, FMT_MEM = 2'd3;
    localparam logic [2:0] OP2_BICC    = 3'b010;
    localparam logic [5:0] OP3_LD      = 6'h00;
    localparam logic [5:0] OP3_ST      = 6'h04;
    localparam logic [5:0] OP3_ALU_LIM = 6'h38;

    // States that hold MFA high waiting for MFC
    function automatic logic is_wait(state_t s);
        return s inside {ST_F1, ST_L1, ST_S2};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Integer branch condition evaluation on the PSR condition codes.
// cond[3] inverts the sense of the base condition in cond[2:0].
module cond_eval (
    input  logic [3:0] cond,
    input  logic       N,
    input  logic       Z,
    input  logic       V,
    input  logic       C,
    output logic       taken
);

    logic base;

    // Base condition select, then optional inversion
    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = Z;
            3'd2: base = Z | (N ^ V);
            3'd3: base = N ^ V;
            3'd4: base = C | Z;
            3'd5: base = C;
            3'd6: base = N;
            3'd7: base = V;
            default: base = 1'b0;
        endcase
        taken = base ^ cond[3];
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired fetch/decode/execute sequencer for the SPARC-subset datapath.
// Every output is a registered decode of the state being entered, so it is
// stable for the whole cycle the FSM spends in that state.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        V,
    input  logic        C,
    input  logic        MFC,
    output logic        IRE,
    output logic        MDRE,
    output logic        MARE,
    output logic        PCE,
    output logic        nPCE,
    output logic        PSRE,
    output logic        RFE,
    output logic        ClrPC,
    output logic        MFA,
    output logic        MOP_SEL,
    output logic        AOP_SEL,
    output logic        RA_SEL,
    output logic [1:0]  nPC_SEL,
    output logic [1:0]  ALU_SEL,
    output logic [1:0]  CIN_SEL,
    output logic [1:0]  RC_SEL,
    output logic [1:0]  MAR_SEL,
    output logic [1:0]  MDR_SEL,
    output logic [5:0]  OP1,
    output logic        illegal,
    output logic        mem_err,
    output logic [4:0]  state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic          taken_q, taken_d, br_tk;

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic [1:0] sel_b;

    assign op    = IR[31:30];
    assign op2   = IR[24:22];
    assign op3   = IR[24:19];
    assign sel_b = IR[13] ? ALU_SIMM : ALU_RFB;
    assign state = cur;

    // Annul bit, rs1/rs2 and immediates are consumed by the datapath only
    logic unused_ir;
    assign unused_ir = ^{IR[29], IR[18:14], IR[12:0]};

    cond_eval u_cond (
        .cond  (IR[28:25]),
        .N     (N),
        .Z     (Z),
        .V     (V),
        .C     (C),
        .taken (br_tk)
    );

    // Next state and branch-taken capture; condition codes are only read in DEC
    always_comb begin
        nxt     = cur;
        taken_d = taken_q;
        case (cur)
            ST_RST:  nxt = ClrPC ? ST_RST : ST_F0;   // stay one extra cycle to pulse ClrPC
            ST_F0:   nxt = ST_F1;
            ST_F1, ST_L1, ST_S2: begin
                if (MFC)
                    nxt = (cur == ST_F1) ? ST_F2 : (cur == ST_L1) ? ST_L2 : ST_UPD;
                else if (cnt == CW'(MEM_TIMEOUT - 1))
                    nxt = ST_MERR;
            end
            ST_F2:   nxt = ST_DEC;
            ST_DEC: begin
                taken_d = 1'b0;
                nxt     = ST_ILL;
                case (op)
                    FMT_ALU:  if (op3 < OP3_ALU_LIM) nxt = ST_ALU;
                    FMT_MEM: begin
                        if (op3 == OP3_LD)      nxt = ST_L0;
                        else if (op3 == OP3_ST) nxt = ST_S0;
                    end
                    FMT_BR: begin
                        if (op2 == OP2_BICC) begin
                            nxt     = ST_UPD;
                            taken_d = br_tk;
                        end
                    end
                    FMT_CALL: begin
                        nxt     = ST_CALL;
                        taken_d = 1'b1;
                    end
                    default: nxt = ST_ILL;
                endcase
            end
            ST_ALU:  nxt = ST_UPD;
            ST_L0:   nxt = ST_L1;
            ST_L2:   nxt = ST_L3;
            ST_L3:   nxt = ST_UPD;
            ST_S0:   nxt = ST_S1;
            ST_S1:   nxt = ST_S2;
            ST_CALL: nxt = ST_UPD;
            ST_UPD:  nxt = ST_F0;
            ST_ILL:  nxt = ST_ILL;
            ST_MERR: nxt = ST_MERR;
            default: nxt = ST_RST;
        endcase
    end

    // State, wait counter and registered output decode of the entered state
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cur     <= ST_RST;
            cnt     <= '0;
            taken_q <= 1'b0;
            IRE <= 1'b1; MDRE <= 1'b1; MARE <= 1'b1; PCE <= 1'b1;
            nPCE <= 1'b1; PSRE <= 1'b1; RFE <= 1'b1; ClrPC <= 1'b1;
            MFA <= 1'b0; MOP_SEL <= 1'b0; AOP_SEL <= 1'b0; RA_SEL <= 1'b0;
            nPC_SEL <= '0; ALU_SEL <= '0; CIN_SEL <= '0; RC_SEL <= '0;
            MAR_SEL <= '0; MDR_SEL <= '0; OP1 <= '0;
            illegal <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            cur     <= nxt;
            taken_q <= taken_d;
            // Counter restarts on every wait-state entry, counts MFC=0 cycles
            if (is_wait(nxt) && nxt == cur) cnt <= cnt + CW'(1);
            else                            cnt <= '0;

            IRE <= 1'b1; MDRE <= 1'b1; MARE <= 1'b1; PCE <= 1'b1;
            nPCE <= 1'b1; PSRE <= 1'b1; RFE <= 1'b1; ClrPC <= 1'b1;
            MFA <= 1'b0; MOP_SEL <= 1'b0; AOP_SEL <= 1'b0; RA_SEL <= 1'b0;
            nPC_SEL <= NPC_INC; ALU_SEL <= ALU_RFB; CIN_SEL <= CIN_PC; RC_SEL <= RC_IR;
            MAR_SEL <= MAR_ALU; MDR_SEL <= MDR_RAM; OP1 <= OP_ADD;
            illegal <= illegal | (nxt == ST_ILL);
            mem_err <= mem_err | (nxt == ST_MERR);

            case (nxt)
                ST_RST:  ClrPC <= 1'b0;
                ST_F0: begin
                    MAR_SEL <= MAR_PC;
                    MARE    <= 1'b0;
                end
                ST_F1, ST_L1: begin
                    MFA     <= 1'b1;
                    MOP_SEL <= 1'b1;
                    OP1     <= OP_LDW;
                end
                ST_F2: begin
                    MDR_SEL <= MDR_RAM;
                    MDRE    <= 1'b0;
                    IRE     <= 1'b0;
                end
                ST_ALU: begin
                    ALU_SEL <= sel_b;
                    RC_SEL  <= RC_IR;
                    CIN_SEL <= CIN_ALU;
                    RFE     <= 1'b0;
                    PSRE    <= ~op3[4];     // only the cc variants update PSR
                end
                ST_L0, ST_S0: begin
                    AOP_SEL <= 1'b1;
                    OP1     <= OP_ADD;
                    ALU_SEL <= sel_b;
                    MAR_SEL <= MAR_ALU;
                    MARE    <= 1'b0;
                end
                ST_L2:   MDRE <= 1'b0;
                ST_L3: begin
                    RC_SEL  <= RC_IR;
                    CIN_SEL <= CIN_MDR;
                    RFE     <= 1'b0;
                end
                ST_S1: begin
                    RA_SEL  <= 1'b1;
                    MDR_SEL <= MDR_RFA;
                    MDRE    <= 1'b0;
                end
                ST_S2: begin
                    MFA     <= 1'b1;
                    MOP_SEL <= 1'b1;
                    OP1     <= OP_STW;
                end
                ST_CALL: begin
                    RC_SEL  <= RC_R15;
                    CIN_SEL <= CIN_PC;
                    RFE     <= 1'b0;
                end
                ST_UPD: begin
                    PCE     <= 1'b0;
                    nPCE    <= 1'b0;
                    nPC_SEL <= taken_d ? NPC_BR : NPC_INC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each instruction pushes its expected
// per-cycle output vectors, which are popped and compared once per cycle.
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Clr, N, Z, V, C, MFC;
    logic [31:0] IR;
    logic        IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, ClrPC, MFA;
    logic        MOP_SEL, AOP_SEL, RA_SEL, illegal, mem_err;
    logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL;
    logic [5:0]  OP1;
    logic [4:0]  state;

    always #5 Clk = ~Clk;

    control_unit dut (
        .Clk(Clk), .Clr(Clr), .IR(IR), .N(N), .Z(Z), .V(V), .C(C), .MFC(MFC),
        .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE), .PSRE(PSRE),
        .RFE(RFE), .ClrPC(ClrPC), .MFA(MFA), .MOP_SEL(MOP_SEL), .AOP_SEL(AOP_SEL),
        .RA_SEL(RA_SEL), .nPC_SEL(nPC_SEL), .ALU_SEL(ALU_SEL), .CIN_SEL(CIN_SEL),
        .RC_SEL(RC_SEL), .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .OP1(OP1),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    typedef struct packed {
        logic ire, mdre, mare, pce, npce, psre, rfe, clrpc, mfa, mop_sel, aop_sel, ra_sel;
        logic [1:0] npc_sel, alu_sel, cin_sel, rc_sel, mar_sel, mdr_sel;
        logic [5:0] op1;
        logic illegal, mem_err;
    } obs_t;

    typedef enum int {
        P_RST, P_PULSE, P_F0, P_F1, P_F2, P_DEC, P_ALU, P_L0, P_L1, P_L2, P_L3,
        P_S0, P_S1, P_S2, P_CALL, P_UPD, P_ILL, P_MERR
    } ph_t;

    obs_t obs;
    assign obs = {IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, ClrPC, MFA, MOP_SEL, AOP_SEL, RA_SEL,
                  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL, OP1, illegal, mem_err};

    int    checks = 0;
    int    fails  = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs while sitting in each phase
    function automatic obs_t expect_of(ph_t p, logic [31:0] ir, bit tk);
        obs_t e;
        e = '0;
        e.ire = 1; e.mdre = 1; e.mare = 1; e.pce = 1; e.npce = 1; e.psre = 1; e.rfe = 1; e.clrpc = 1;
        case (p)
            P_PULSE: e.clrpc = 0;
            P_F0:    begin e.mar_sel = 2'd1; e.mare = 0; end
            P_F1, P_L1: begin e.mfa = 1; e.mop_sel = 1; e.op1 = 6'h08; end
            P_F2:    begin e.mdre = 0; e.ire = 0; end
            P_ALU:   begin e.alu_sel = {1'b0, ir[13]}; e.cin_sel = 2'd2; e.rfe = 0; e.psre = ~ir[23]; end
            P_L0, P_S0: begin e.aop_sel = 1; e.alu_sel = {1'b0, ir[13]}; e.mare = 0; end
            P_L2:    e.mdre = 0;
            P_L3:    begin e.cin_sel = 2'd3; e.rfe = 0; end
            P_S1:    begin e.ra_sel = 1; e.mdr_sel = 2'd1; e.mdre = 0; end
            P_S2:    begin e.mfa = 1; e.mop_sel = 1; e.op1 = 6'h04; end
            P_CALL:  begin e.rc_sel = 2'd3; e.rfe = 0; end
            P_UPD:   begin e.pce = 0; e.npce = 0; e.npc_sel = tk ? 2'd2 : 2'd0; end
            P_ILL:   e.illegal = 1;
            P_MERR:  e.mem_err = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit ref_cond(logic [3:0] cd, logic n, logic z, logic v, logic c);
        case (cd)
            4'h0: return 0;              4'h8: return 1;
            4'h1: return z;              4'h9: return !z;
            4'h2: return z | (n ^ v);    4'hA: return !(z | (n ^ v));
            4'h3: return n ^ v;          4'hB: return !(n ^ v);
            4'h4: return c | z;          4'hC: return !(c | z);
            4'h5: return c;              4'hD: return !c;
            4'h6: return n;              4'hE: return !n;
            default: return (cd == 4'h7) ? v : !v;
        endcase
    endfunction

    task automatic push(input ph_t p, input logic [31:0] ir, input bit tk, input string lbl);
        exp_q.push_back(expect_of(p, ir, tk));
        tag_q.push_back($sformatf("%s_%s", lbl, p.name()));
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge Clk);
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        Clr = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_vals", obs, expect_of(P_RST, '0, 0));
        Clr = 1'b1;
        push(P_PULSE, '0, 0, "rst");
        drain();
    endtask

    // Drive one instruction and queue its whole expected cycle sequence
    task automatic run_instr(input logic [31:0] ir, input logic [3:0] nzvc, input int ill_cycles, input string lbl);
        bit il;
        il = 0;
        IR = ir;
        {N, Z, V, C} = nzvc;
        push(P_F0, ir, 0, lbl); push(P_F1, ir, 0, lbl); push(P_F2, ir, 0, lbl); push(P_DEC, ir, 0, lbl);
        case (ir[31:30])
            2'd2: if (ir[24:19] < 6'h38) begin push(P_ALU, ir, 0, lbl); push(P_UPD, ir, 0, lbl); end
                  else il = 1;
            2'd3: if (ir[24:19] == 6'h00) begin
                      push(P_L0, ir, 0, lbl); push(P_L1, ir, 0, lbl); push(P_L2, ir, 0, lbl);
                      push(P_L3, ir, 0, lbl); push(P_UPD, ir, 0, lbl);
                  end else if (ir[24:19] == 6'h04) begin
                      push(P_S0, ir, 0, lbl); push(P_S1, ir, 0, lbl); push(P_S2, ir, 0, lbl);
                      push(P_UPD, ir, 0, lbl);
                  end else il = 1;
            2'd0: if (ir[24:22] == 3'b010) push(P_UPD, ir, ref_cond(ir[28:25], nzvc[3], nzvc[2], nzvc[1], nzvc[0]), lbl);
                  else il = 1;
            default: begin push(P_CALL, ir, 0, lbl); push(P_UPD, ir, 1, lbl); end
        endcase
        if (il) repeat (ill_cycles) push(P_ILL, ir, 0, lbl);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b0; MFC = 1'b1; IR = '0; {N, Z, V, C} = 4'b0000;
        do_reset();

        // Reset asserted in the middle of a fetch wait
        MFC = 1'b0;
        push(P_F0, '0, 0, "midf1"); push(P_F1, '0, 0, "midf1"); push(P_F1, '0, 0, "midf1");
        drain();
        #2 Clr = 1'b0;
        #1 chk("clr_async_midF1", obs, expect_of(P_RST, '0, 0));
        @(negedge Clk);
        chk("clr_held", obs, expect_of(P_RST, '0, 0));
        Clr = 1'b1; MFC = 1'b1;
        push(P_PULSE, '0, 0, "rel");
        drain();

        run_instr(32'hA2044012, 4'b0000, 0, "add");
        run_instr({2'b10, 5'd1, 6'h14, 5'd1, 1'b1, 13'd5}, 4'b0000, 0, "subcc");
        run_instr(32'h02800004, 4'b0100, 0, "be_z1");
        run_instr(32'h02800004, 4'b0000, 0, "be_z0");
        for (int i = 0; i < 6; i++) begin
            logic [3:0] cd;
            logic [3:0] fl;
            cd = 4'($urandom_range(0, 15));
            fl = 4'($urandom_range(0, 15));
            run_instr({2'b00, 1'b0, cd, 3'b010, 22'd4}, fl, 0, $sformatf("bicc%0d", i));
        end
        run_instr(32'hC2006008, 4'b0000, 0, "ld");
        run_instr(32'hC2206008, 4'b0000, 0, "st");
        run_instr(32'h40000010, 4'b0000, 0, "call");
        run_instr(32'h81F80000, 4'b0000, 5, "ill");

        // Fetch that never completes
        do_reset();
        MFC = 1'b0;
        push(P_F0, '0, 0, "tmo");
        repeat (15) push(P_F1, '0, 0, "tmo");
        repeat (3) push(P_MERR, '0, 0, "tmo");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hard-wired control unit for the SPARC-subset datapath. Runs the fetch/decode/execute sequence and drives every enable, mux select, ALU/memory opcode and memory handshake signal of the datapath from the current IR, the condition codes and MFC. It replaces manual, bench-driven sequencing of those signals and sits directly upstream of the datapath as its only controller.

## Interface
- MEM_TIMEOUT, 15: max cycles MFA may stay high without MFC before `mem_err`.
- Clk  in  1  clock; all state changes on rising edge.
- Clr  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents.
- N, Z, V, C  in  1 each  condition codes from PSR.
- MFC  in  1  memory function complete.
- IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE  out  1 each  register load enables, active-low; reset 1.
- ClrPC  out  1  PC clear, active-low; reset 1.
- MFA  out  1  memory function request, active-high; reset 0.
- MOP_SEL, AOP_SEL, RA_SEL  out  1 each  0 = field from IR, 1 = OP1 / rd; reset 0.
- nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL  out  2 each  datapath mux selects; reset 0.
- OP1  out  6  forced ALU/memory opcode; reset 0.
- illegal  out  1  sticky, unsupported opcode; reset 0.
- mem_err  out  1  sticky, memory timeout; reset 0.
- state  out  5  current state encoding, for debug.

## Operation
- Mux encodings: MAR_SEL 0 = ALU, 1 = PC.
  - MDR_SEL 0 = RAM, 1 = RF A.
  - CIN_SEL 0 = PC, 2 = ALU, 3 = MDR.
  - RC_SEL 0 = IR[29:25], 3 = r15.
  - ALU_SEL 0 = RF B, 1 = simm13.
  - nPC_SEL 0 = nPC+4, 2 = branch target.
  - RA_SEL 0 = IR[18:14], 1 = IR[29:25].
- Memory opcodes: 6'h08 load word, 6'h04 store word. ALU add = 6'h00.
- States and transitions:
  - RST: ClrPC=0 for one cycle → F0. nPC reset to 4 is done by the datapath from Clr.
  - F0: MAR_SEL=1, MARE=0 → F1.
  - F1: MFA=1, MOP_SEL=1, OP1=08. Hold until MFC=1 → F2.
  - F2: MDR_SEL=0, MDRE=0, IRE=0 → DEC.
  - DEC: decode IR[31:30]; no outputs asserted.
    - op=2, op3<6'h38 → ALU.
    - op=3, op3=00 → L0; op3=04 → S0.
    - op=0, op2=010 → UPD with branch evaluation.
    - op=1 → CALL.
    - anything else → ILL.
  - ALU: AOP_SEL=0, RA_SEL=0, ALU_SEL=IR[13]?1:0, RC_SEL=0, CIN_SEL=2, RFE=0. PSRE=0 when op3[4]=1 (cc variants) → UPD.
  - L0: AOP_SEL=1, OP1=00, ALU_SEL=IR[13]?1:0, MAR_SEL=0, MARE=0 → L1.
  - L1: as F1 → L2 on MFC.
  - L2: MDR_SEL=0, MDRE=0 → L3.
  - L3: RC_SEL=0, CIN_SEL=3, RFE=0 → UPD.
  - S0: as L0 → S1.
  - S1: RA_SEL=1, MDR_SEL=1, MDRE=0 → S2.
  - S2: MFA=1, MOP_SEL=1, OP1=04 → UPD on MFC.
  - CALL: RC_SEL=3, CIN_SEL=0, RFE=0 → UPD with target forced.
  - UPD: PCE=0, nPCE=0. nPC_SEL=2 if taken branch or CALL, else 0 → F0. Delay slot is inherent in this PC/nPC update.
  - ILL: `illegal`=1, all enables inactive; held until reset.
  - MERR: `mem_err`=1; held until reset.
- Branch conditions on IR[28:25]:
  - 8 → always; 0 → never.
  - 1/9 → Z / !Z.
  - 2/10 → Z|(N^V) / inverse.
  - 3/11 → N^V / inverse.
  - 4/12 → C|Z / inverse.
  - 5/13 → C / !C.
  - 6/14 → N / !N.
  - 7/15 → V / !V.
  - Annul bit ignored.

## Timing
- Outputs are registered decodes of state, valid the whole cycle; they are never combinational from MFC.
- MFA rises on entry to F1/L1/S2 and stays high while MFC=0. The edge sampling MFC=1 leaves the state, and MFA=0 in the next state.
- Timeout counter resets on each wait-state entry and increments per cycle while MFC=0. At MEM_TIMEOUT → MERR.
- Latency with MFC=1 in the first wait cycle:
  - ALU: 6 cycles (F0, F1, F2, DEC, ALU, UPD).
  - Branch: 5 cycles.
  - CALL: 6 cycles.
  - Load: 9 cycles.
  - Store: 8 cycles.
- Clr low in any state, including mid-wait: immediately forces RST, all outputs to reset values, and counter to 0.
- Reads of N/Z/V/C occur in DEC and are held in a 1-bit `taken` register until UPD.

## Structure
- Package `ctrl_pkg`: state enum, mux-select constants, memory and ALU opcode constants, op/op2/op3 field constants.
- Sub-module `cond_eval`: combinational, inputs cond[3:0] and N, Z, V, C; output taken.

## Test plan
- Reset: Clr low mid-F1 with MFA=1 → MFA=0 and all enables 1 immediately; ClrPC=0 for one cycle after release.
- IR=0xA2044012 (add r17,r17,r18), MFC immediate:
  - RFE=0 with RC_SEL=0, CIN_SEL=2, ALU_SEL=0 in cycle 5.
  - PCE=nPCE=0 with nPC_SEL=0 in cycle 6.
- IR=0x02800004 (BE):
  - Z=1 → UPD nPC_SEL=2.
  - Z=0 → nPC_SEL=0.
  - 5 cycles total.
- IR=0xC2006008 (ld): L0 ALU_SEL=1, OP1=00, MARE=0; L1 OP1=08; L3 CIN_SEL=3, RFE=0.
- IR=0xC2206008 (st): S1 RA_SEL=1, MDR_SEL=1; S2 OP1=04. Then IR with op=2, op3=6'h3F → illegal=1, no enable low afterwards.
- MFC held 0 in F1 → mem_err=1 after 15 cycles; MFA=0 thereafter.
